// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Once imem_req rises it stays high with imem_addr stable until the cycle imem_ack is seen;
    // imem_ack/imem_rdata may arrive in the same cycle as the request (zero-wait memory).
    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack bus into a small queue and feeds IF/ID.
// Optional IF_PERF_CNT_EN adds fetched/bubble/redirect counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FB_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        imem,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [31:0]               seOut,
    input  logic                      jump,
    input  logic [25:0]               jump_target,
    input  logic                      jr,
    input  logic [31:0]               reg_Da,
    output logic [31:0]               Instructions,
    output logic [31:0]               instr_pc,
    output logic                      if_flush,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_bubbles,
    output logic [31:0]               perf_redirects,
`endif
    output logic [1:0]                fsm_state
);
    localparam int PW = $clog2(FB_DEPTH);
    localparam int CW = $clog2(FB_DEPTH + 1);

    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} state_t;

    state_t        state;
    logic [31:0]   pc, req_addr, pc_d1, pc_d2;
    logic [31:0]   q_pc    [FB_DEPTH];
    logic [31:0]   q_instr [FB_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic          redirect, fire, take, bypass, push, pop, empty, full;
    logic [31:0]   seq_pc, target;

    // pc_d2 is the PC of the instruction now in EX, so all targets are relative to it.
    always_comb begin
        seq_pc = pc_d2 + 32'd4;
        target = seq_pc + (seOut << 2);
        if (jr)
            target = reg_Da & ~32'd3;
        else if (jump)
            target = {seq_pc[31:28], jump_target, 2'b00};
    end

    assign redirect       = jr | jump | branch_taken;
    assign empty          = (count == '0);
    assign full           = (count == CW'(FB_DEPTH));
    assign imem.imem_req  = rst && ((state != S_REQ) || !full);
    assign imem.imem_addr = (state == S_REQ) ? pc : req_addr;
    assign fire           = imem.imem_req && imem.imem_ack;
    // Data from a dropped request or arriving on a redirect edge is wrong-path.
    assign take           = fire && (state != S_DROP) && !redirect;
    assign bypass         = take && empty && !stall;
    assign push           = take && !bypass;
    assign pop            = !redirect && !stall && !empty;
    assign if_flush       = rst && redirect;
    assign fsm_state      = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            Instructions <= 32'h0;
            instr_pc     <= 32'h0;
            pc_d1        <= 32'h0;
            pc_d2        <= 32'h0;
`ifdef IF_PERF_CNT_EN
            perf_fetched   <= 32'h0;
            perf_bubbles   <= 32'h0;
            perf_redirects <= 32'h0;
`endif
        end else begin
            case (state)
                S_REQ:   if (imem.imem_req && !imem.imem_ack) state <= redirect ? S_DROP : S_WAIT;
                S_WAIT:  if (imem.imem_ack) state <= S_REQ;
                         else if (redirect) state <= S_DROP;
                S_DROP:  if (imem.imem_ack) state <= S_REQ;
                default: state <= S_REQ;
            endcase
            if (state == S_REQ)
                req_addr <= pc;

            if (redirect)
                pc <= target;
            else if (take)
                pc <= pc + 32'd4;

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end

            if (redirect) begin
                Instructions <= 32'h0;
            end else if (!stall) begin
                if (!empty) begin
                    Instructions <= q_instr[rd_ptr];
                    instr_pc     <= q_pc[rd_ptr];
                end else if (bypass) begin
                    Instructions <= imem.imem_rdata;
                    instr_pc     <= imem.imem_addr;
                end else begin
                    Instructions <= 32'h0;
                end
            end

            if (redirect || !stall) begin
                pc_d1 <= instr_pc;
                pc_d2 <= pc_d1;
            end
`ifdef IF_PERF_CNT_EN
            perf_fetched   <= perf_fetched + 32'(take);
            perf_bubbles   <= perf_bubbles + 32'(!redirect && !stall && empty && !bypass);
            perf_redirects <= perf_redirects + 32'(redirect);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= imem.imem_addr;
            q_instr[wr_ptr] <= imem.imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench: variable-latency instruction memory, random stalls/redirects/resets,
// every cycle compared against a queue-based fetch model.
module tb_instr_fetch_unit;
    localparam int          FB_DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          N_CYC    = 3000;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump, jr;
    logic [31:0] seOut, reg_Da;
    logic [25:0] jump_target;
    logic [31:0] Instructions, instr_pc;
    logic        if_flush;
    logic [1:0]  fsm_state;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles, perf_redirects;
`endif

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FB_DEPTH(FB_DEPTH)) dut (
        .clk(clk), .rst(rst), .imem(bus),
        .stall(stall), .branch_taken(branch_taken), .seOut(seOut),
        .jump(jump), .jump_target(jump_target), .jr(jr), .reg_Da(reg_Da),
        .Instructions(Instructions), .instr_pc(instr_pc), .if_flush(if_flush),
`ifdef IF_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
        .perf_redirects(perf_redirects),
`endif
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [63:0] exp_q[$];          // {pc, instr} words fetched but not yet issued
    logic        m_out, m_drop;     // a request is in flight / its data is wrong-path
    logic [31:0] m_pc, m_oaddr, m_instr, m_ipc, m_d1, m_d2;
    logic [31:0] m_fetched, m_bubbles, m_redirs;
    logic        mem_busy;
    int          mem_left, lat_max, stall_pct, redir_pct, rst_pm;
    int          total = 0, bad = 0, cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_out = 1'b0; m_drop = 1'b0;
        m_pc = RESET_PC; m_oaddr = RESET_PC;
        m_instr = 32'h0; m_ipc = 32'h0; m_d1 = 32'h0; m_d2 = 32'h0;
        m_fetched = 32'h0; m_bubbles = 32'h0; m_redirs = 32'h0;
    endtask

    function automatic logic model_req();
        return rst && (m_out || (exp_q.size() < FB_DEPTH));
    endfunction

    task automatic model_step();
        logic        redir, ereq, got, data;
        logic [31:0] seq, tgt, faddr, word, old_ipc;
        logic [63:0] head;
        if (!rst) begin
            model_reset();
        end else begin
            redir = jr | jump | branch_taken;
            seq   = m_d2 + 32'd4;
            if (jr)        tgt = reg_Da & 32'hFFFF_FFFC;
            else if (jump) tgt = {seq[31:28], jump_target, 2'b00};
            else           tgt = seq + seOut * 32'd4;
            ereq  = model_req();
            faddr = m_out ? m_oaddr : m_pc;
            got   = ereq && bus.imem_ack;
            data  = got && !m_drop && !redir;
            word  = mem_word(faddr);
            if (got) begin
                m_out = 1'b0; m_drop = 1'b0;
            end else if (ereq) begin
                m_out = 1'b1; m_oaddr = faddr; m_drop = m_drop | redir;
            end
            if (redir)     m_pc = tgt;
            else if (data) m_pc = faddr + 32'd4;

            old_ipc = m_ipc;
            if (redir) begin
                m_instr = 32'h0;
                exp_q.delete();
                m_redirs++;
            end else if (stall) begin
                if (data) exp_q.push_back({faddr, word});
            end else if (exp_q.size() > 0) begin
                head = exp_q.pop_front();
                m_ipc = head[63:32];
                m_instr = head[31:0];
                if (data) exp_q.push_back({faddr, word});
            end else if (data) begin
                m_ipc = faddr;
                m_instr = word;
            end else begin
                m_instr = 32'h0;
                m_bubbles++;
            end
            if (data) m_fetched++;
            if (!stall || redir) begin
                m_d2 = m_d1;
                m_d1 = old_ipc;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_inputs();
        lat_max   = (cyc < 200) ? 0 : (cyc < 1500) ? 2 : 3;
        stall_pct = (cyc < 13) ? 0 : (cyc < 16) ? 100 : (cyc < 40) ? 0 : (cyc < 1500) ? 20 : 50;
        redir_pct = (cyc < 40) ? 0 : 10;
        rst_pm    = (cyc < 40) ? 0 : 5;
        rst   = (cyc < 3) ? 1'b0 : (32'($urandom_range(0, 999)) >= 32'(rst_pm));
        stall = (32'($urandom_range(0, 99)) < 32'(stall_pct));
        if (32'($urandom_range(0, 99)) < 32'(redir_pct))
            {jr, jump, branch_taken} = 3'($urandom_range(1, 7));
        else
            {jr, jump, branch_taken} = 3'b000;
        seOut       = 32'($urandom_range(0, 64)) - 32'd32;
        jump_target = 26'($urandom);
        reg_Da      = ($urandom_range(0, 1) != 0) ? $urandom
                                                  : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
    endtask

    task automatic mem_respond();
        if (!rst) begin
            mem_busy       = 1'b0;
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
        end else begin
            if (bus.imem_req && !mem_busy) begin
                mem_busy = 1'b1;
                mem_left = $urandom_range(0, lat_max);
            end
            bus.imem_ack   = bus.imem_req && mem_busy && (mem_left == 0);
            bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : $urandom;
        end
    endtask

    task automatic mem_advance();
        if (rst) begin
            if (bus.imem_ack)              mem_busy = 1'b0;
            else if (mem_busy && mem_left > 0) mem_left--;
        end
    endtask

    // ---------------- main ----------------
    initial begin
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        seOut = 32'h0; reg_Da = 32'h0; jump_target = 26'h0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        mem_busy = 1'b0; mem_left = 0; lat_max = 0;
        model_reset();
        for (cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            drive_inputs();
            #1;
            mem_respond();
            #1;
            if (cyc > 0) begin
                check("imem_req", 32'(bus.imem_req), 32'(model_req()));
                if (model_req())
                    check("imem_addr", bus.imem_addr, m_out ? m_oaddr : m_pc);
                check("if_flush", 32'(if_flush), 32'(rst && (jr | jump | branch_taken)));
                check("Instructions", Instructions, m_instr);
                check("instr_pc", instr_pc, m_ipc);
                check("fsm_legal", 32'(fsm_state != 2'b11), 32'd1);
            end
            model_step();
            mem_advance();
        end
`ifdef IF_PERF_CNT_EN
        @(negedge clk);
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_bubbles", perf_bubbles, m_bubbles);
        check("perf_redirects", perf_redirects, m_redirs);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
